// File: rtl/knn_select_if.sv
// Sample stream into knn_select: packed {dx, dy} differences plus a training-point label.
// Handshake: a sample transfers on a rising clk edge where valid && ready; the master
// holds diff/label stable while valid is high, and ready may drop without notice.
interface knn_select_if #(
  parameter int LABEL_W = 4
);
  logic               valid;
  logic               ready;
  logic [31:0]        diff;
  logic [LABEL_W-1:0] label;

  modport master (output valid, output diff, output label, input ready);
  modport slave  (input valid, input diff, input label, output ready);
endinterface

// File: rtl/knn_select.sv
// K-nearest-neighbour selector: squares per-axis differences, keeps a sorted list of the K
// closest points. Define KNN_VOTE_EN to build the majority-vote FSM and its ports.
module knn_select #(
  parameter int K       = 4,
  parameter int LABEL_W = 4,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  knn_select_if.slave        smp,
  output logic [IDX_W:0]     count,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [31:0]        rd_dist,
  output logic [LABEL_W-1:0] rd_label
`ifdef KNN_VOTE_EN
  ,
  input  logic               vote_start,
  output logic               vote_done,
  output logic [LABEL_W-1:0] vote_label,
  output logic [1:0]         vote_state
`endif
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [31:0] EMPTY_DIST = 32'hFFFF_FFFF;

  // ---------------------------------------------------------------------------
  // Stage 1: squared distance
  // ---------------------------------------------------------------------------
  logic               accept;
  logic signed [15:0] dx;
  logic signed [15:0] dy;
  logic signed [31:0] dx_sq;
  logic signed [31:0] dy_sq;
  logic [31:0]        sq_sum;

  logic               s1_valid;
  logic [31:0]        s1_dist;
  logic [LABEL_W-1:0] s1_label;

  assign accept = smp.valid && smp.ready;
  assign dx     = smp.diff[31:16];
  assign dy     = smp.diff[15:0];
  assign dx_sq  = dx * dx;
  assign dy_sq  = dy * dy;
  // Each square is at most 2**30, so the unsigned sum cannot wrap.
  assign sq_sum = $unsigned(dx_sq) + $unsigned(dy_sq);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
    end
    if (accept) begin
      s1_dist  <= sq_sum;
      s1_label <= smp.label;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: sorted insertion
  // ---------------------------------------------------------------------------
  logic [31:0]        dist_q  [K];
  logic [LABEL_W-1:0] label_q [K];
  logic [31:0]        dist_d  [K];
  logic [LABEL_W-1:0] label_d [K];
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [K-1:0]       ins;

  // ins[i]: the new sample belongs at or before slot i. Strict compare keeps ties stable.
  always_comb begin
    ins     = '0;
    dist_d  = dist_q;
    label_d = label_q;
    count_d = count_q;
    for (int i = 0; i < K; i++) begin
      ins[i] = (CNT_W'(i) >= count_q) || (s1_dist < dist_q[i]);
    end
    if (s1_valid) begin
      if (ins[0]) begin
        dist_d[0]  = s1_dist;
        label_d[0] = s1_label;
      end
      for (int i = 1; i < K; i++) begin
        if (ins[i]) begin
          if (ins[i-1]) begin
            dist_d[i]  = dist_q[i-1];
            label_d[i] = label_q[i-1];
          end else begin
            dist_d[i]  = s1_dist;
            label_d[i] = s1_label;
          end
        end
      end
      if (count_q < CNT_W'(K)) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < K; i++) begin
        dist_q[i]  <= EMPTY_DIST;
        label_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      dist_q  <= dist_d;
      label_q <= label_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

  always_comb begin
    rd_dist  = EMPTY_DIST;
    rd_label = '0;
    for (int i = 0; i < K; i++) begin
      if ((IDX_W'(i) == rd_idx) && (CNT_W'(i) < count_q)) begin
        rd_dist  = dist_q[i];
        rd_label = label_q[i];
      end
    end
  end

`ifdef KNN_VOTE_EN
  // ---------------------------------------------------------------------------
  // Majority vote: tally kept labels, then scan for the highest tally
  // ---------------------------------------------------------------------------
  localparam int NLAB = 2 ** LABEL_W;

  typedef enum logic [1:0] {
    V_IDLE  = 2'd0,
    V_TALLY = 2'd1,
    V_PICK  = 2'd2,
    V_DONE  = 2'd3
  } vote_state_t;

  vote_state_t        state_q;
  vote_state_t        state_d;
  logic [4:0]         tally [NLAB];
  logic [IDX_W-1:0]   tidx;
  logic [LABEL_W-1:0] pidx;
  logic [CNT_W-1:0]   vote_n;
  logic [4:0]         best_cnt;
  logic [LABEL_W-1:0] best_label;
  logic [LABEL_W-1:0] cur_label;
  logic               tally_last;
  logic               pick_better;

  assign smp.ready   = !clear && (state_q == V_IDLE);
  assign vote_done   = (state_q == V_DONE);
  assign vote_state  = state_q;
  assign tally_last  = (CNT_W'(tidx) + CNT_W'(1)) == vote_n;
  assign pick_better = tally[pidx] > best_cnt;

  always_comb begin
    cur_label = '0;
    for (int i = 0; i < K; i++) begin
      if (IDX_W'(i) == tidx) begin
        cur_label = label_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= V_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      V_IDLE:  if (vote_start) state_d = (count_q == '0) ? V_PICK : V_TALLY;
      V_TALLY: if (tally_last) state_d = V_PICK;
      V_PICK:  if (&pidx) state_d = V_DONE;
      V_DONE:  state_d = V_IDLE;
      default: state_d = V_IDLE;
    endcase
    if (clear) begin
      state_d = V_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NLAB; i++) begin
        tally[i] <= '0;
      end
      tidx       <= '0;
      pidx       <= '0;
      vote_n     <= '0;
      best_cnt   <= '0;
      best_label <= '0;
      vote_label <= '0;
    end else begin
      case (state_q)
        V_IDLE: begin
          if (vote_start) begin
            for (int i = 0; i < NLAB; i++) begin
              tally[i] <= '0;
            end
            tidx       <= '0;
            pidx       <= '0;
            vote_n     <= count_q;
            best_cnt   <= '0;
            best_label <= '0;
          end
        end
        V_TALLY: begin
          tally[cur_label] <= tally[cur_label] + 5'd1;
          tidx             <= tidx + IDX_W'(1);
        end
        V_PICK: begin
          if (pick_better) begin
            best_cnt   <= tally[pidx];
            best_label <= pidx;
          end
          pidx <= pidx + LABEL_W'(1);
          if (&pidx) begin
            vote_label <= pick_better ? pidx : best_label;
          end
        end
        default: begin
        end
      endcase
    end
  end
`else
  assign smp.ready = !clear;
`endif

endmodule

// File: tb/tb_knn_select.sv
// Directed self-checking bench for knn_select; the vote scenario is built when
// KNN_VOTE_EN is defined.
module tb_knn_select;
  localparam int K       = 4;
  localparam int LABEL_W = 4;
  localparam int IDX_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic [IDX_W:0]     count;
  logic [IDX_W-1:0]   rd_idx;
  logic [31:0]        rd_dist;
  logic [LABEL_W-1:0] rd_label;
`ifdef KNN_VOTE_EN
  logic               vote_start;
  logic               vote_done;
  logic [LABEL_W-1:0] vote_label;
  logic [1:0]         vote_state;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  knn_select_if #(.LABEL_W(LABEL_W)) smp ();

  knn_select #(.K(K), .LABEL_W(LABEL_W), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .smp        (smp),
    .count      (count),
    .rd_idx     (rd_idx),
    .rd_dist    (rd_dist),
    .rd_label   (rd_label)
`ifdef KNN_VOTE_EN
    ,
    .vote_start (vote_start),
    .vote_done  (vote_done),
    .vote_label (vote_label),
    .vote_state (vote_state)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge
  task automatic drive(input logic [15:0] dx, input logic [15:0] dy, input logic [LABEL_W-1:0] lb);
    @(negedge clk);
    smp.valid = 1'b1;
    smp.diff  = {dx, dy};
    smp.label = lb;
  endtask

  task automatic idle();
    @(negedge clk);
    smp.valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    smp.valid = 1'b0;
    clear     = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
  endtask

  task automatic read(input int i);
    rd_idx = i[IDX_W-1:0];
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    read(0);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (rd_dist !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_dist got=%0h exp=ffffffff", rd_dist); end
    total++; if (rd_label !== 4'd0) begin bad++; $display("FAIL reset_label got=%0d exp=0", rd_label); end
    total++; if (smp.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", smp.ready); end
  endtask

  task automatic test_squaring();
    drive(16'hFFFD, 16'h0004, 4'd2);
    idle();
    read(0);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL sq_latency_count got=%0d exp=0", count); end
    @(negedge clk);
    read(0);
    total++; if (rd_dist !== 32'd25) begin bad++; $display("FAIL sq_dist got=%0d exp=25", rd_dist); end
    total++; if (rd_label !== 4'd2) begin bad++; $display("FAIL sq_label got=%0d exp=2", rd_label); end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL sq_count got=%0d exp=1", count); end
    drive(16'h8000, 16'h8000, 4'd7);
    idle();
    @(negedge clk);
    read(1);
    total++; if (rd_dist !== 32'h8000_0000) begin bad++; $display("FAIL sq_max_dist got=%0h exp=80000000", rd_dist); end
    total++; if (rd_label !== 4'd7) begin bad++; $display("FAIL sq_max_label got=%0d exp=7", rd_label); end
    total++; if (count !== 5'd2) begin bad++; $display("FAIL sq_max_count got=%0d exp=2", count); end
    read(2);
    total++; if (rd_dist !== 32'hFFFF_FFFF) begin bad++; $display("FAIL empty_dist got=%0h exp=ffffffff", rd_dist); end
    total++; if (rd_label !== 4'd0) begin bad++; $display("FAIL empty_label got=%0d exp=0", rd_label); end
  endtask

  task automatic test_back_to_back_sort();
    logic [LABEL_W-1:0] lbl_exp [4];
    logic [31:0] e;
    do_clear();
    // distances 50,10,29,40,20,61 with labels 1..6
    drive(16'd7, 16'd1, 4'd1);
    drive(16'd3, 16'hFFFF, 4'd2);
    drive(16'hFFFB, 16'd2, 4'd3);
    drive(16'd6, 16'd2, 4'd4);
    drive(16'd4, 16'hFFFE, 4'd5);
    drive(16'd6, 16'd5, 4'd6);
    idle();
    @(negedge clk);
    exp_q = {32'd10, 32'd20, 32'd29, 32'd40};
    lbl_exp = '{4'd2, 4'd5, 4'd3, 4'd4};
    total++; if (count !== 5'd4) begin bad++; $display("FAIL sort_count got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      read(i);
      e = exp_q.pop_front();
      total++; if (rd_dist !== e) begin bad++; $display("FAIL sort_dist[%0d] got=%0d exp=%0d", i, rd_dist, e); end
      total++; if (rd_label !== lbl_exp[i]) begin bad++; $display("FAIL sort_label[%0d] got=%0d exp=%0d", i, rd_label, lbl_exp[i]); end
    end
    // equal to the last entry while full: discarded
    drive(16'd6, 16'd2, 4'd7);
    idle();
    @(negedge clk);
    read(3);
    total++; if (count !== 5'd4) begin bad++; $display("FAIL discard_count got=%0d exp=4", count); end
    total++; if (rd_label !== 4'd4) begin bad++; $display("FAIL discard_label got=%0d exp=4", rd_label); end
    // new nearest while full: 40 falls off
    drive(16'd2, 16'd0, 4'd8);
    idle();
    @(negedge clk);
    read(0);
    total++; if (rd_dist !== 32'd4 || rd_label !== 4'd8) begin bad++; $display("FAIL shift_head got=%0d/%0d exp=4/8", rd_dist, rd_label); end
    read(3);
    total++; if (rd_dist !== 32'd29 || rd_label !== 4'd3) begin bad++; $display("FAIL shift_tail got=%0d/%0d exp=29/3", rd_dist, rd_label); end
  endtask

  task automatic test_ties();
    do_clear();
    drive(16'd3, 16'd0, 4'd1);
    drive(16'd0, 16'hFFFD, 4'd3);
    idle();
    @(negedge clk);
    read(0);
    total++; if (rd_dist !== 32'd9 || rd_label !== 4'd1) begin bad++; $display("FAIL tie_e0 got=%0d/%0d exp=9/1", rd_dist, rd_label); end
    read(1);
    total++; if (rd_dist !== 32'd9 || rd_label !== 4'd3) begin bad++; $display("FAIL tie_e1 got=%0d/%0d exp=9/3", rd_dist, rd_label); end
  endtask

  task automatic test_clear();
    do_clear();
    @(negedge clk);
    smp.valid = 1'b1;
    smp.diff  = {16'd1, 16'd1};
    smp.label = 4'd5;
    clear     = 1'b1;
    #1;
    total++; if (smp.ready !== 1'b0) begin bad++; $display("FAIL clear_ready got=%0b exp=0", smp.ready); end
    @(negedge clk);
    clear     = 1'b0;
    smp.diff  = {16'd2, 16'd2};
    @(negedge clk);
    smp.valid = 1'b0;
    clear     = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
    repeat (2) @(negedge clk);
    read(0);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL clear_count got=%0d exp=0", count); end
    total++; if (rd_dist !== 32'hFFFF_FFFF) begin bad++; $display("FAIL clear_dist got=%0h exp=ffffffff", rd_dist); end
  endtask

  task automatic test_rst_mid();
    do_clear();
    drive(16'd1, 16'd1, 4'd1);
    @(negedge clk);
    smp.valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    @(negedge clk);
    read(0);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    total++; if (rd_dist !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rstmid_dist got=%0h exp=ffffffff", rd_dist); end
  endtask

`ifdef KNN_VOTE_EN
  task automatic test_vote();
    int done_at;
    int ready_bad;
    logic [LABEL_W-1:0] got_label;
    done_at   = -1;
    ready_bad = 0;
    got_label = '0;
    do_clear();
    drive(16'd1, 16'd0, 4'd2);
    drive(16'd1, 16'd1, 4'd5);
    drive(16'd2, 16'd0, 4'd2);
    drive(16'd2, 16'd1, 4'd5);
    idle();
    @(negedge clk);
    @(negedge clk);
    vote_start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      vote_start = 1'b0;
      #1;
      if (done_at < 0) begin
        if (smp.ready !== 1'b0) ready_bad++;
        if (vote_done === 1'b1) begin
          done_at   = cyc;
          got_label = vote_label;
        end
      end
    end
    total++; if (done_at != 21) begin bad++; $display("FAIL vote_latency got=%0d exp=21", done_at); end
    total++; if (got_label !== 4'd2) begin bad++; $display("FAIL vote_label got=%0d exp=2", got_label); end
    total++; if (ready_bad != 0) begin bad++; $display("FAIL vote_ready got=%0d high cycles exp=0", ready_bad); end
    total++; if (vote_done !== 1'b0 || vote_label !== 4'd2) begin bad++; $display("FAIL vote_after got=%0b/%0d exp=0/2", vote_done, vote_label); end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    rd_idx    = '0;
    smp.valid = 1'b0;
    smp.diff  = '0;
    smp.label = '0;
`ifdef KNN_VOTE_EN
    vote_start = 1'b0;
`endif
    test_reset();
    test_squaring();
    test_back_to_back_sort();
    test_ties();
    test_clear();
    test_rst_mid();
`ifdef KNN_VOTE_EN
    test_vote();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
